// File: rtl/avm_pattern_master_if.sv
// Avalon-MM bus bundle between the pattern master and the on-chip memory s1 port.
interface avm_pattern_master_if #(
  parameter int unsigned ADDR_W = 14
);
  logic [ADDR_W-1:0] avm_address;
  logic              avm_chipselect;
  logic              avm_write;
  logic              avm_read;
  logic [3:0]        avm_byteenable;
  logic [31:0]       avm_writedata;
  logic [31:0]       avm_readdata;
  logic              avm_waitrequest;

  modport master (
    output avm_address, avm_chipselect, avm_write, avm_read, avm_byteenable, avm_writedata,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_write, avm_read, avm_byteenable, avm_writedata,
    output avm_readdata, avm_waitrequest
  );
endinterface

// File: rtl/avm_pattern_master.sv
// Avalon-MM master that fills a memory block with seed+i, or reads it back and
// counts words that differ from the same pattern.
module avm_pattern_master #(
  parameter int unsigned ADDR_W       = 14,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              op,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic [31:0]       seed,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   error_count,
  output logic [ADDR_W-1:0] first_err_addr,
  avm_pattern_master_if.master avm
);

  localparam int unsigned   LAST = READ_LATENCY - 1;
  localparam logic [ADDR_W:0] ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_CHECK,
    S_DRAIN,
    S_FIN
  } state_t;

  state_t state, next;

  logic [ADDR_W-1:0] base_r;
  logic [ADDR_W:0]   count_r;
  logic [31:0]       seed_r;
  logic [ADDR_W:0]   idx;

  logic [READ_LATENCY-1:0] vld;
  logic [ADDR_W:0]         pix [READ_LATENCY];

  logic wr, rd, accept, last, pending, mismatch;

  assign last     = (idx == count_r - ONE);
  assign accept   = (wr | rd) & ~avm.avm_waitrequest;
  assign mismatch = vld[LAST] && (avm.avm_readdata != seed_r + 32'(pix[LAST]));

  always_comb begin
    next    = state;
    wr      = 1'b0;
    rd      = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    pending = 1'b0;
    // entries not yet at the output stage still have data to arrive
    for (int unsigned i = 0; i + 1 < READ_LATENCY; i++) pending = pending | vld[i];
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (word_count == '0) next = S_FIN;
          else if (op)          next = S_CHECK;
          else                  next = S_FILL;
        end
      end
      S_FILL: begin
        busy = 1'b1;
        wr   = 1'b1;
        if (!avm.avm_waitrequest && last) next = S_FIN;
      end
      S_CHECK: begin
        busy = 1'b1;
        rd   = 1'b1;
        if (!avm.avm_waitrequest && last) next = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (!pending) next = S_FIN;
      end
      S_FIN: begin
        done = 1'b1;
        next = S_IDLE;
      end
      default: next = S_IDLE;
    endcase
  end

  assign avm.avm_write      = wr;
  assign avm.avm_read       = rd;
  assign avm.avm_chipselect = wr | rd;
  assign avm.avm_byteenable = (wr | rd) ? 4'b1111 : 4'b0000;
  assign avm.avm_address    = base_r + idx[ADDR_W-1:0];
  assign avm.avm_writedata  = seed_r + 32'(idx);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base_r         <= '0;
      count_r        <= '0;
      seed_r         <= '0;
      idx            <= '0;
      vld            <= '0;
      error_count    <= '0;
      first_err_addr <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        base_r         <= base_addr;
        count_r        <= word_count;
        seed_r         <= seed;
        idx            <= '0;
        error_count    <= '0;
        first_err_addr <= '0;
      end else begin
        if (accept) idx <= idx + ONE;
        if (mismatch) begin
          if (error_count == '0) first_err_addr <= base_r + pix[LAST][ADDR_W-1:0];
          if (error_count != '1) error_count <= error_count + ONE;
        end
      end
      vld[0] <= rd & ~avm.avm_waitrequest;
      pix[0] <= idx;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        vld[i] <= vld[i-1];
        pix[i] <= pix[i-1];
      end
    end
  end

endmodule

// File: tb/tb_avm_pattern_master.sv
// Bench for avm_pattern_master: RAM slave model, request scoreboard, latency and result checks.
module tb_avm_pattern_master;
  localparam int unsigned AW = 14;

  logic          clk = 1'b0;
  logic          reset, start, op;
  logic [AW-1:0] base_addr;
  logic [AW:0]   word_count;
  logic [31:0]   seed;
  logic          busy, done;
  logic [AW:0]   error_count;
  logic [AW-1:0] first_err_addr;

  avm_pattern_master_if #(.ADDR_W(AW)) avm ();

  avm_pattern_master #(.ADDR_W(AW), .READ_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .base_addr(base_addr),
    .word_count(word_count), .seed(seed), .busy(busy), .done(done),
    .error_count(error_count), .first_err_addr(first_err_addr), .avm(avm)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          rd;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } req_t;
  req_t exp_q[$];

  logic [31:0]   mem [0:(1<<AW)-1];
  logic          wait_en = 1'b0;
  logic          corrupt_en = 1'b0;
  logic [AW-1:0] corrupt_addr = '0;

  // Single-port RAM slave, one-cycle read latency
  always @(posedge clk) begin
    if (corrupt_en) mem[corrupt_addr] <= '0;
    else if (avm.avm_chipselect && avm.avm_write && !avm.avm_waitrequest)
      mem[avm.avm_address] <= avm.avm_writedata;
    if (avm.avm_chipselect && avm.avm_read && !avm.avm_waitrequest)
      avm.avm_readdata <= mem[avm.avm_address];
  end

  always @(posedge clk) begin
    #2;
    avm.avm_waitrequest = wait_en ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  task automatic run_cmd(input logic o, input logic [AW-1:0] b, input logic [AW:0] n,
                         input logic [31:0] s, input int poke_cyc,
                         output int lat, output int busy_bad);
    req_t          e;
    logic          ps;
    logic [AW-1:0] pa;
    logic [31:0]   pd;
    logic          pw, pr;
    int            cyc;
    for (int i = 0; i < int'(n); i++) begin
      e.rd = o; e.addr = b + AW'(i); e.data = s + 32'(i);
      exp_q.push_back(e);
    end
    @(negedge clk);
    op = o; base_addr = b; word_count = n; seed = s; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1; busy_bad = 0; ps = 1'b0; cyc = 0;
    pa = '0; pd = '0; pw = 1'b0; pr = 1'b0;
    while (lat < 0 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (cyc == poke_cyc + 1) start = 1'b0;
      if (ps) begin
        checks++;
        if (avm.avm_address !== pa || avm.avm_writedata !== pd ||
            avm.avm_write !== pw || avm.avm_read !== pr) begin
          errors++;
          $display("FAIL stall_hold addr %h want %h data %h want %h wr %b/%b rd %b/%b",
                   avm.avm_address, pa, avm.avm_writedata, pd, avm.avm_write, pw, avm.avm_read, pr);
        end
      end
      if (avm.avm_chipselect) begin
        checks++;
        if (avm.avm_byteenable !== 4'hF) begin
          errors++;
          $display("FAIL byteenable got %h want f", avm.avm_byteenable);
        end
        if (!avm.avm_waitrequest) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_req addr %h rd %b got request want none", avm.avm_address, avm.avm_read);
          end else begin
            e = exp_q.pop_front();
            if (avm.avm_read !== e.rd || avm.avm_write !== !e.rd || avm.avm_address !== e.addr ||
                (!e.rd && avm.avm_writedata !== e.data)) begin
              errors++;
              $display("FAIL request got rd=%b addr=%h data=%h want rd=%b addr=%h data=%h",
                       avm.avm_read, avm.avm_address, avm.avm_writedata, e.rd, e.addr, e.data);
            end
          end
        end
      end
      if (done) begin
        lat = cyc;
        if (busy) busy_bad++;
      end else if (!busy) busy_bad++;
      if (cyc == poke_cyc) begin
        start = 1'b1; op = ~o; base_addr = b + AW'(100); word_count = 2; seed = ~s;
      end
      ps = avm.avm_chipselect & avm.avm_waitrequest;
      pa = avm.avm_address; pd = avm.avm_writedata; pw = avm.avm_write; pr = avm.avm_read;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_req got %0d outstanding want 0", exp_q.size());
      exp_q.delete();
    end
    if (start) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic corrupt(input logic [AW-1:0] a);
    @(negedge clk);
    corrupt_addr = a; corrupt_en = 1'b1;
    @(negedge clk);
    corrupt_en = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; op = 1'b0; base_addr = '0; word_count = '0; seed = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, avm.avm_chipselect, avm.avm_read, avm.avm_write} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 00000", {busy, done, avm.avm_chipselect, avm.avm_read, avm.avm_write});
    end
    checks++;
    if (error_count !== '0 || first_err_addr !== '0 || avm.avm_address !== '0 || avm.avm_writedata !== '0) begin
      errors++;
      $display("FAIL reset_data got ec=%h fa=%h addr=%h wd=%h want all 0",
               error_count, first_err_addr, avm.avm_address, avm.avm_writedata);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fill_basic;
    int lat, bb;
    run_cmd(1'b0, 14'h0010, 15'd4, 32'hA000_0000, -5, lat, bb);
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL fill_latency got %0d want 5", lat); end
    checks++;
    if (bb !== 0) begin errors++; $display("FAIL fill_busy got %0d bad cycles want 0", bb); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_pulse got %b want 0", done); end
  endtask

  task automatic test_check_basic;
    int lat, bb;
    run_cmd(1'b1, 14'h0010, 15'd4, 32'hA000_0000, -5, lat, bb);
    checks++;
    if (lat !== 6) begin errors++; $display("FAIL check_latency got %0d want 6", lat); end
    checks++;
    if (bb !== 0) begin errors++; $display("FAIL check_busy got %0d bad cycles want 0", bb); end
    checks++;
    if (error_count !== 15'd0) begin errors++; $display("FAIL check_clean got %0d want 0", error_count); end
  endtask

  task automatic test_check_errors;
    int lat, bb;
    corrupt(14'h0012);
    run_cmd(1'b1, 14'h0010, 15'd4, 32'hA000_0000, -5, lat, bb);
    checks++;
    if (error_count !== 15'd1 || first_err_addr !== 14'h0012) begin
      errors++;
      $display("FAIL one_error got ec=%0d fa=%h want ec=1 fa=0012", error_count, first_err_addr);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (error_count !== 15'd1 || first_err_addr !== 14'h0012) begin
      errors++;
      $display("FAIL result_hold got ec=%0d fa=%h want ec=1 fa=0012", error_count, first_err_addr);
    end
    corrupt(14'h0011);
    run_cmd(1'b1, 14'h0010, 15'd4, 32'hA000_0000, -5, lat, bb);
    checks++;
    if (error_count !== 15'd2 || first_err_addr !== 14'h0011) begin
      errors++;
      $display("FAIL two_errors got ec=%0d fa=%h want ec=2 fa=0011", error_count, first_err_addr);
    end
    run_cmd(1'b0, 14'h0010, 15'd4, 32'hA000_0000, -5, lat, bb);
    run_cmd(1'b1, 14'h0010, 15'd4, 32'hA000_0000, -5, lat, bb);
    checks++;
    if (error_count !== 15'd0 || first_err_addr !== 14'h0000) begin
      errors++;
      $display("FAIL clear_on_start got ec=%0d fa=%h want ec=0 fa=0000", error_count, first_err_addr);
    end
  endtask

  task automatic test_wrap;
    int lat, bb;
    run_cmd(1'b0, 14'h3FFE, 15'd4, 32'h1234_5678, -5, lat, bb);
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL wrap_latency got %0d want 5", lat); end
    run_cmd(1'b1, 14'h3FFE, 15'd4, 32'h1234_5678, -5, lat, bb);
    checks++;
    if (error_count !== 15'd0) begin errors++; $display("FAIL wrap_check got %0d want 0", error_count); end
    run_cmd(1'b0, 14'h3FFE, 15'd0, 32'h1234_5678, -5, lat, bb);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL zero_count_latency got %0d want 1", lat); end
    run_cmd(1'b1, 14'h0100, 15'd0, 32'h0, -5, lat, bb);
    checks++;
    if (lat !== 1 || bb !== 0) begin errors++; $display("FAIL zero_count_check got lat=%0d bb=%0d want 1/0", lat, bb); end
  endtask

  task automatic test_random_wait;
    int lat, bb;
    logic [31:0] s;
    s = $urandom;
    wait_en = 1'b1;
    run_cmd(1'b0, 14'h0200, 15'd16, s, -5, lat, bb);
    checks++;
    if (lat < 17) begin errors++; $display("FAIL wait_fill_latency got %0d want >=17", lat); end
    run_cmd(1'b1, 14'h0200, 15'd16, s, -5, lat, bb);
    checks++;
    if (lat < 18 || bb !== 0) begin errors++; $display("FAIL wait_check got lat=%0d bb=%0d want >=18/0", lat, bb); end
    checks++;
    if (error_count !== 15'd0) begin errors++; $display("FAIL wait_errors got %0d want 0", error_count); end
    wait_en = 1'b0;
  endtask

  task automatic test_reset_mid;
    int seen;
    @(negedge clk);
    op = 1'b1; base_addr = 14'h0200; word_count = 15'd16; seed = 32'h5555_0000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, avm.avm_chipselect, avm.avm_read, avm.avm_write} !== 5'b0 ||
        avm.avm_address !== '0 || avm.avm_writedata !== '0 || error_count !== '0) begin
      errors++;
      $display("FAIL mid_reset got ctl=%b addr=%h wd=%h ec=%0d want all 0",
               {busy, done, avm.avm_chipselect, avm.avm_read, avm.avm_write},
               avm.avm_address, avm.avm_writedata, error_count);
    end
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done || busy || avm.avm_chipselect) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL post_reset_activity got %0d cycles want 0", seen); end
  endtask

  task automatic test_start_while_busy;
    int lat, bb;
    run_cmd(1'b0, 14'h0300, 15'd8, 32'hCAFE_0000, 3, lat, bb);
    checks++;
    if (lat !== 9 || bb !== 0) begin errors++; $display("FAIL busy_start got lat=%0d bb=%0d want 9/0", lat, bb); end
    run_cmd(1'b1, 14'h0300, 15'd8, 32'hCAFE_0000, -5, lat, bb);
    checks++;
    if (error_count !== 15'd0) begin errors++; $display("FAIL busy_start_data got %0d want 0", error_count); end
  endtask

  task automatic test_back_to_back;
    int lat, bb;
    run_cmd(1'b0, 14'h0400, 15'd3, 32'hFFFF_FFFE, 4, lat, bb);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL fin_start got busy=%b want 0", busy); end
    run_cmd(1'b1, 14'h0400, 15'd3, 32'hFFFF_FFFE, -5, lat, bb);
    checks++;
    if (lat !== 5 || error_count !== 15'd0) begin
      errors++;
      $display("FAIL back_to_back got lat=%0d ec=%0d want 5/0", lat, error_count);
    end
  endtask

  initial begin
    test_reset;
    test_fill_basic;
    test_check_basic;
    test_check_errors;
    test_wrap;
    test_random_wait;
    test_reset_mid;
    test_start_while_busy;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
